// File: rtl/riscv_modq_unit.sv
// ---------------------------------------------------------------------------
// riscv_modq_unit
//
// Modular-arithmetic coprocessor for the custom-0 opcode space. It sits next
// to the M unit and uses the same valid/busy/ready/wr handshake.
//
// Operations, all modulo the compile-time prime Q:
//   funct3 000  ADDMOD  rd = (rs1 + rs2) mod Q   (single cycle, rs1,rs2 < Q)
//   funct3 001  SUBMOD  rd = (rs1 - rs2) mod Q   (single cycle, rs1,rs2 < Q)
//   funct3 010  MODQ    rd = rs1 mod Q           (iterative, any rs1)
//   funct3 011  MULMOD  rd = (rs1 * rs2) mod Q   (iterative, rs1 < Q)
// MODQ and MULMOD retire UNROLL operand bits per cycle, MSB first.
//
// Ports:
//   clk          in   1     clock, rising edge
//   resetn       in   1     asynchronous active-low reset
//   valid        in   1     instruction/operands presented this cycle
//   instruction  in   32    full instruction word
//   rs1          in   XLEN  operand A
//   rs2          in   XLEN  operand B
//   wr           out  1     write rd back (legal completions only)
//   rd           out  XLEN  result; holds until next legal completion
//   busy         out  1     high while iterating
//   ready        out  1     one-cycle completion pulse
//   illegal      out  1     one-cycle pulse with ready on illegal encoding
// ---------------------------------------------------------------------------
module riscv_modq_unit #(
  parameter int         XLEN          = 32,
  parameter int         Q             = 3329,
  parameter int         UNROLL        = 1,
  parameter logic [6:0] OPCODE_CUSTOM = 7'b0001011
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            valid,
  input  logic [31:0]     instruction,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  output logic            wr,
  output logic [XLEN-1:0] rd,
  output logic            busy,
  output logic            ready,
  output logic            illegal
);

  localparam int STEPS = XLEN / UNROLL;
  localparam int CW    = $clog2(STEPS) + 1;

  // Modulus widened to the internal remainder width so every compare and
  // subtract below is done on XLEN+1 bits.
  localparam logic [XLEN:0] Q_W = (XLEN+1)'(Q);

  localparam logic [2:0] F3_ADDMOD = 3'b000;
  localparam logic [2:0] F3_SUBMOD = 3'b001;
  localparam logic [2:0] F3_MODQ   = 3'b010;
  localparam logic [2:0] F3_MULMOD = 3'b011;
  localparam logic [6:0] F7_MODQ   = 7'b0000001;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state;
  state_t          state_next;

  logic [CW-1:0]   count_q;
  logic [XLEN:0]   r_q;
  logic [XLEN:0]   r_next;
  logic [XLEN-1:0] shift_q;
  logic [XLEN-1:0] addend_q;
  logic [XLEN-1:0] rd_q;
  logic            mul_q;
  logic            illegal_q;

  // Instruction fields
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       op_match;
  logic       legal;
  logic       long_op;
  logic       accept;

  // Register-specifier fields are not needed by this unit.
  logic       unused_bits;

  assign opcode      = instruction[6:0];
  assign funct3      = instruction[14:12];
  assign funct7      = instruction[31:25];
  assign unused_bits = ^{instruction[24:15], instruction[11:7]};

  // funct3 values 100..111 are reserved, so bit 2 alone marks them illegal.
  assign op_match = (opcode == OPCODE_CUSTOM);
  assign legal    = (funct7 == F7_MODQ) && !funct3[2];
  assign long_op  = legal && funct3[1];

  // A new instruction may be taken in IDLE or DONE, so back-to-back issue
  // needs no idle cycle; while iterating, valid is ignored entirely.
  assign accept = valid && op_match && (state != CALC);

  // ---------------------------------------------------------------------
  // Single-cycle ADDMOD / SUBMOD. Both work on XLEN+1 bits so the carry
  // (add) or the sign (sub) is visible before the single correction step.
  // ---------------------------------------------------------------------
  logic [XLEN:0]   sum;
  logic [XLEN:0]   diff;
  logic [XLEN-1:0] add_res;
  logic [XLEN-1:0] sub_res;

  assign sum     = {1'b0, rs1} + {1'b0, rs2};
  assign diff    = {1'b0, rs1} - {1'b0, rs2};
  assign add_res = (sum >= Q_W) ? XLEN'(sum - Q_W) : sum[XLEN-1:0];
  assign sub_res = diff[XLEN] ? XLEN'(diff + Q_W) : diff[XLEN-1:0];

  // ---------------------------------------------------------------------
  // Iteration datapath: UNROLL reduction steps chained combinationally.
  // shift_q holds the operand being scanned with its next bit at the MSB.
  // MODQ:   r = 2r + bit, then one conditional subtract of Q.
  // MULMOD: r = 2r reduced, then r += rs1 reduced when the bit is set.
  // Because r < Q < 2**(XLEN-1) before each step, 2r and r + rs1 stay
  // below 2**XLEN and one subtract of Q is always enough.
  // ---------------------------------------------------------------------
  always_comb begin
    r_next = r_q;
    for (int i = 0; i < UNROLL; i++) begin
      if (mul_q) begin
        r_next = {r_next[XLEN-1:0], 1'b0};
        if (r_next >= Q_W) r_next = r_next - Q_W;
        if (shift_q[XLEN-1-i]) begin
          r_next = r_next + {1'b0, addend_q};
          if (r_next >= Q_W) r_next = r_next - Q_W;
        end
      end else begin
        r_next = {r_next[XLEN-1:0], shift_q[XLEN-1-i]};
        if (r_next >= Q_W) r_next = r_next - Q_W;
      end
    end
  end

  // ---------------------------------------------------------------------
  // State register.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // ---------------------------------------------------------------------
  // Next-state and handshake outputs. ready/busy decode straight from the
  // state so an asynchronous reset clears them immediately.
  // ---------------------------------------------------------------------
  always_comb begin
    state_next = state;
    ready      = 1'b0;
    busy       = 1'b0;
    wr         = 1'b0;
    illegal    = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (accept) begin
          state_next = long_op ? CALC : DONE;
        end else begin
          state_next = IDLE;
        end
        if (state == DONE) begin
          ready   = 1'b1;
          wr      = !illegal_q;
          illegal = illegal_q;
        end
      end
      CALC: begin
        busy = 1'b1;
        if (count_q == '0) state_next = DONE;
      end
      default: state_next = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------
  // Datapath registers. Operands are captured on accept so later changes
  // on rs1/rs2 cannot disturb an iteration in progress. rd is only written
  // on a legal completion; an illegal encoding leaves it untouched.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      count_q   <= '0;
      r_q       <= '0;
      shift_q   <= '0;
      addend_q  <= '0;
      rd_q      <= '0;
      mul_q     <= 1'b0;
      illegal_q <= 1'b0;
    end else if (accept) begin
      illegal_q <= !legal;
      mul_q     <= (funct3 == F3_MULMOD);
      shift_q   <= (funct3 == F3_MODQ) ? rs1 : rs2;
      addend_q  <= rs1;
      r_q       <= '0;
      count_q   <= CW'(STEPS - 1);
      if (legal && (funct3 == F3_ADDMOD)) rd_q <= add_res;
      if (legal && (funct3 == F3_SUBMOD)) rd_q <= sub_res;
    end else if (state == CALC) begin
      r_q     <= r_next;
      shift_q <= shift_q << UNROLL;
      count_q <= count_q - 1'b1;
      if (count_q == '0) rd_q <= r_next[XLEN-1:0];
    end
  end

  assign rd = rd_q;

endmodule
